link_n: RTL

Parametrised N-input wormhole packet merger with registered output. It arbitrates packets from `N` upstream channels onto one output channel using round-robin priority, and holds the grant from the first accepted flit to the tail. A two-entry output buffer removes every combinational path from `ready_i` to the input readies and sustains one flit per cycle. It sits at router output ports and local-inject merge points wherever more than one source feeds a link.

---
 rtl/link_n.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/link_n.sv
// N-input wormhole packet merger: round-robin arbitration with the grant held
// from the opening flit to the tail, feeding a two-entry registered output buffer.
module link_n #(
  parameter int unsigned N           = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [1:0]  TYPE_HEAD   = 2'b00,
  parameter logic [1:0]  TYPE_BODY   = 2'b01,
  parameter logic [1:0]  TYPE_TAIL   = 2'b10,
  parameter logic [1:0]  TYPE_SINGLE = 2'b11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*DATA_WIDTH-1:0] in_data_i,
  input  logic [N-1:0]            in_valid_i,
  output logic [N-1:0]            in_ready_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [N-1:0]            owner_o
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         own_idx_q, own_idx_d;
  logic [N-1:0]          owner_q, owner_d;
  logic [1:0]            count_q, count_d;
  logic                  space_q, valid_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

  logic [IW-1:0]         win_idx, sel_idx;
  logic                  win_found;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [1:0]            sel_type;
  logic                  push, pop;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    int unsigned idx;
    logic [IW-1:0] idx_w;
    idx       = 0;
    idx_w     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx   = (32'(ptr_q) + k) % N;
      idx_w = IW'(idx);
      if (!win_found && in_valid_i[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  assign sel_idx  = (state_q == S_LOCKED) ? own_idx_q : win_idx;
  assign sel_data = in_data_i[32'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_type = sel_data[DATA_WIDTH-1 -: 2];

  // Readies depend only on registered space, never on ready_i.
  always_comb begin
    in_ready_o = '0;
    if (!rst && space_q) begin
      if (state_q == S_LOCKED) begin
        in_ready_o = owner_q;
      end else if (win_found) begin
        in_ready_o[win_idx] = 1'b1;
      end
    end
  end

  assign push    = |(in_valid_i & in_ready_o);
  assign pop     = valid_q & ready_i;
  assign valid_o = valid_q;
  assign data_o  = buf0_q;
  assign owner_o = owner_q;

  // Packet lock and arbitration pointer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_idx_d = own_idx_q;
    owner_d   = owner_q;
    if (push) begin
      if (state_q == S_IDLE) begin
        ptr_d = win_idx;
        if (sel_type == TYPE_HEAD || sel_type == TYPE_BODY) begin
          state_d   = S_LOCKED;
          own_idx_d = win_idx;
          owner_d   = N'(1) << win_idx;
        end
      end else if (sel_type == TYPE_TAIL || sel_type == TYPE_SINGLE) begin
        state_d = S_IDLE;
        owner_d = '0;
      end
    end
  end

  // Two-entry FIFO; buf0 is always the oldest entry.
  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) buf0_d = sel_data;
        else                 buf1_d = sel_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        buf0_d  = buf1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          buf0_d = sel_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = sel_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= IW'(N - 1);
      own_idx_q <= '0;
      owner_q   <= '0;
      count_q   <= 2'd0;
      space_q   <= 1'b1;
      valid_q   <= 1'b0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_idx_q <= own_idx_d;
      owner_q   <= owner_d;
      count_q   <= count_d;
      space_q   <= (count_d != 2'd2);
      valid_q   <= (count_d != 2'd0);
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
    end
  end

endmodule
